// File: rtl/traffic_pkg.sv
// Shared lamp, phase and pattern definitions for the traffic lamp checker.
// Lamp codes are {red,yellow,green}; exactly one lamp lit is a clean code.
package traffic_pkg;

    localparam int RED = 2;
    localparam int YEL = 1;
    localparam int GRN = 0;

    localparam logic [2:0] LAMP_R = 3'(1 << RED);
    localparam logic [2:0] LAMP_Y = 3'(1 << YEL);
    localparam logic [2:0] LAMP_G = 3'(1 << GRN);

    typedef enum logic [2:0] {
        PH_SYNC        = 3'd0,
        PH_EW_G        = 3'd1,
        PH_EW_Y        = 3'd2,
        PH_ALL_R_TO_NS = 3'd3,
        PH_NS_G        = 3'd4,
        PH_NS_Y        = 3'd5,
        PH_ALL_R_TO_EW = 3'd6
    } phase_e;

    typedef enum logic [2:0] {
        PAT_ALL_R,
        PAT_EW_G,
        PAT_EW_Y,
        PAT_NS_G,
        PAT_NS_Y,
        PAT_INVALID
    } pattern_e;

    function automatic logic lamp_ok(input logic [2:0] l);
        return (l == LAMP_R) || (l == LAMP_Y) || (l == LAMP_G);
    endfunction

    // Pattern that keeps a tracked phase where it is.
    function automatic pattern_e hold_pattern(input phase_e p);
        pattern_e r;
        r = PAT_INVALID;
        case (p)
            PH_EW_G:        r = PAT_EW_G;
            PH_EW_Y:        r = PAT_EW_Y;
            PH_NS_G:        r = PAT_NS_G;
            PH_NS_Y:        r = PAT_NS_Y;
            PH_ALL_R_TO_NS: r = PAT_ALL_R;
            PH_ALL_R_TO_EW: r = PAT_ALL_R;
            default:        r = PAT_INVALID;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/traffic_pattern_decode.sv
// Combinational decode of the four registered lamp buses into an axis
// pattern plus the onehot, pairing and axis-conflict indications.
module traffic_pattern_decode
    import traffic_pkg::*;
(
    input  logic [2:0] east,
    input  logic [2:0] south,
    input  logic [2:0] west,
    input  logic [2:0] north,
    output pattern_e   pattern,
    output logic       bad_onehot,
    output logic       bad_pair,
    output logic       conflict
);

    always_comb begin
        bad_onehot = !lamp_ok(east) || !lamp_ok(south) ||
                     !lamp_ok(west) || !lamp_ok(north);
        bad_pair   = (east != west) || (south != north);
        // Anything other than a clean red counts as showing a go aspect.
        conflict   = (east != LAMP_R) && (south != LAMP_R);
        pattern    = PAT_INVALID;
        if (!bad_onehot && !bad_pair) begin
            case ({east, south})
                {LAMP_G, LAMP_R}: pattern = PAT_EW_G;
                {LAMP_Y, LAMP_R}: pattern = PAT_EW_Y;
                {LAMP_R, LAMP_G}: pattern = PAT_NS_G;
                {LAMP_R, LAMP_Y}: pattern = PAT_NS_Y;
                {LAMP_R, LAMP_R}: pattern = PAT_ALL_R;
                default:          pattern = PAT_INVALID;
            endcase
        end
    end

endmodule

// File: rtl/traffic_led_checker.sv
// Passive monitor of the traffic controller lamp buses: tracks the phase
// sequence, measures dwell times and raises sticky error flags.
module traffic_led_checker
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_YELLOW = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       led_east,
    input  logic [2:0]       led_south,
    input  logic [2:0]       led_west,
    input  logic [2:0]       led_north,
    output logic [2:0]       phase,
    output logic             err_onehot,
    output logic             err_pair,
    output logic             err_conflict,
    output logic             err_seq,
    output logic             err_time,
    output logic             err_any,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y  = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] OVER_Y = CNT_W'(MAX_YELLOW + 1);

    logic [2:0]       east_q;
    logic [2:0]       south_q;
    logic [2:0]       west_q;
    logic [2:0]       north_q;
    phase_e           state_q;
    phase_e           state_d;
    phase_e           nxt;
    logic             first_q;
    logic             first_d;
    pattern_e         prev_pat_q;
    pattern_e         pat;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] dwell_d;
    logic             bad_onehot;
    logic             bad_pair;
    logic             conflict;
    logic             legal;
    logic             seq_hit;
    logic             time_hit;
    logic             cyc_inc;
    logic             is_g;
    logic             is_y;

    traffic_pattern_decode u_decode (
        .east       (east_q),
        .south      (south_q),
        .west       (west_q),
        .north      (north_q),
        .pattern    (pat),
        .bad_onehot (bad_onehot),
        .bad_pair   (bad_pair),
        .conflict   (conflict)
    );

    assign is_g = (state_q == PH_EW_G) || (state_q == PH_NS_G);
    assign is_y = (state_q == PH_EW_Y) || (state_q == PH_NS_Y);

    // Dwell follows the decoded pattern, independent of the tracked state.
    assign dwell_d = (pat != prev_pat_q) ? CNT_W'(1) :
                     (dwell_q == '1)     ? dwell_q   :
                                           dwell_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        seq_hit  = 1'b0;
        time_hit = 1'b0;
        cyc_inc  = 1'b0;
        legal    = 1'b0;
        nxt      = PH_SYNC;
        case (state_q)
            PH_EW_G: begin
                if (pat == PAT_EW_Y) begin
                    legal = 1'b1;
                    nxt   = PH_EW_Y;
                end
            end
            PH_EW_Y: begin
                if (pat == PAT_NS_G) begin
                    legal = 1'b1;
                    nxt   = PH_NS_G;
                end else if (pat == PAT_ALL_R) begin
                    legal = 1'b1;
                    nxt   = PH_ALL_R_TO_NS;
                end
            end
            PH_ALL_R_TO_NS: begin
                if (pat == PAT_NS_G) begin
                    legal = 1'b1;
                    nxt   = PH_NS_G;
                end
            end
            PH_NS_G: begin
                if (pat == PAT_NS_Y) begin
                    legal = 1'b1;
                    nxt   = PH_NS_Y;
                end
            end
            PH_NS_Y: begin
                if (pat == PAT_EW_G) begin
                    legal = 1'b1;
                    nxt   = PH_EW_G;
                end else if (pat == PAT_ALL_R) begin
                    legal = 1'b1;
                    nxt   = PH_ALL_R_TO_EW;
                end
            end
            PH_ALL_R_TO_EW: begin
                if (pat == PAT_EW_G) begin
                    legal = 1'b1;
                    nxt   = PH_EW_G;
                end
            end
            default: ;
        endcase

        if (state_q == PH_SYNC) begin
            if (pat == PAT_EW_G) begin
                state_d = PH_EW_G;
                first_d = 1'b1;
            end else if (pat == PAT_NS_G) begin
                state_d = PH_NS_G;
                first_d = 1'b1;
            end
        end else if (pat != hold_pattern(state_q)) begin
            first_d = 1'b0;
            if (pat == PAT_INVALID) begin
                state_d = PH_SYNC;
            end else begin
                state_d  = legal ? nxt : PH_SYNC;
                seq_hit  = !legal;
                cyc_inc  = legal && (nxt == PH_EW_G);
                // The phase entered from SYNC was seen only partially.
                time_hit = !first_q &&
                           ((is_g && (dwell_q < MIN_G)) ||
                            (is_y && (dwell_q < MIN_Y)));
            end
        end else begin
            time_hit = !first_q && is_y && (dwell_d == OVER_Y);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            east_q       <= LAMP_R;
            south_q      <= LAMP_R;
            west_q       <= LAMP_R;
            north_q      <= LAMP_R;
            state_q      <= PH_SYNC;
            first_q      <= 1'b0;
            prev_pat_q   <= PAT_ALL_R;
            dwell_q      <= '0;
            err_onehot   <= 1'b0;
            err_pair     <= 1'b0;
            err_conflict <= 1'b0;
            err_seq      <= 1'b0;
            err_time     <= 1'b0;
            cycles       <= '0;
        end else begin
            east_q       <= led_east;
            south_q      <= led_south;
            west_q       <= led_west;
            north_q      <= led_north;
            state_q      <= state_d;
            first_q      <= first_d;
            prev_pat_q   <= pat;
            dwell_q      <= dwell_d;
            err_onehot   <= err_onehot | bad_onehot;
            err_pair     <= err_pair | bad_pair;
            err_conflict <= err_conflict | conflict;
            err_seq      <= err_seq | seq_hit;
            err_time     <= err_time | time_hit;
            if (cyc_inc) begin
                cycles <= cycles + CNT_W'(1);
            end
        end
    end

    assign phase   = state_q;
    assign err_any = err_onehot | err_pair | err_conflict |
                     err_seq | err_time;

endmodule

// File: doc/traffic_led_checker.md
Name: traffic_led_checker

Overview:
Passive on-chip monitor that sits on the four 3-bit lamp buses driven by the traffic light controller and checks them continuously. It decodes the lamp patterns into axis phases and tracks the legal phase sequence with a state machine. It measures the dwell time of each phase and raises sticky error flags on illegal lamp codes, axis conflicts, sequence violations and timing violations. It also counts completed light cycles, for the bench and for on-board debug LEDs.

Parameters:
MIN_GREEN, 4, minimum cycles a green phase must persist
MIN_YELLOW, 2, minimum cycles a yellow phase must persist
MAX_YELLOW, 8, maximum cycles a yellow phase may persist
CNT_W, 8, width of the dwell counter and the cycle counter (both saturate or wrap, see Behaviour)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
led_east  in  3  lamp code {red,yellow,green}, bit2=red, bit1=yellow, bit0=green, active-high
led_south  in  3  same encoding
led_west  in  3  same encoding
led_north  in  3  same encoding
phase  out  3  current tracked phase (encodings in package)
err_onehot  out  1  sticky: some direction not exactly one lamp lit
err_pair  out  1  sticky: east!=west or south!=north
err_conflict  out  1  sticky: both axes non-red simultaneously
err_seq  out  1  sticky: illegal phase transition
err_time  out  1  sticky: dwell bound violated
err_any  out  1  OR of the five error flags
cycles  out  CNT_W  completed full rounds, wraps modulo 2^CNT_W

Behaviour:
- Reset: sampled on rising clk while rst_n=0. All err_* flags=0, phase=SYNC, cycles=0, dwell=0, input registers=3'b100. Reset mid-operation clears everything the next edge; no state survives.
- Stage 1 registers all four buses. Stage 2 updates the FSM and flags. An offending input is visible on the error outputs 2 clk edges after it is applied.
- Decode of registered buses: EW axis = east (west must equal it); NS axis = south (north must equal it). Patterns: EW_G (EW green, NS red), EW_Y (EW yellow, NS red), NS_G, NS_Y, ALL_R (both red); anything else = INVALID.
- err_onehot: set if any bus is not one of 001/010/100. err_pair: set if east!=west or south!=north. err_conflict: set if both axes are non-red. These checks are active in every state, including SYNC.
- FSM states: SYNC, EW_G, EW_Y, ALL_R_TO_NS, NS_G, NS_Y, ALL_R_TO_EW.
- SYNC: stays put until the decode reads EW_G or NS_G, then enters that state. No seq or time checks apply in SYNC or during the first phase after it.
- Legal transitions: EW_G->EW_Y; EW_Y->NS_G or ALL_R_TO_NS; ALL_R_TO_NS->NS_G; NS_G->NS_Y; NS_Y->EW_G or ALL_R_TO_EW; ALL_R_TO_EW->EW_G. Staying in the same pattern is always legal.
- Illegal pattern from a tracked state: set err_seq and go to SYNC. An INVALID decode also sends the FSM to SYNC; only the onehot/pair/conflict flags are set for it, not err_seq.
- dwell: resets to 1 on each pattern change and increments each cycle while the pattern holds. Saturates at 2^CNT_W-1.
- err_time is set on:
  - leaving a G state with dwell<MIN_GREEN;
  - leaving a Y state with dwell<MIN_YELLOW;
  - a Y state reaching dwell=MAX_YELLOW+1 (checked live, without waiting for exit).
- cycles increments on each entry into EW_G from NS_Y or ALL_R_TO_EW. Entry from SYNC does not count. Wraps at 2^CNT_W.
- Simultaneous events: every applicable flag is set in the same cycle. Flags are sticky until reset.

Decomposition:
- Package traffic_pkg: lamp bit indices (RED=2, YEL=1, GRN=0), the 3-bit phase encodings (SYNC=0, EW_G=1, EW_Y=2, ALL_R_TO_NS=3, NS_G=4, NS_Y=5, ALL_R_TO_EW=6), and the decoded-pattern enum.
- One sub-module, traffic_pattern_decode: combinational. Takes the four registered buses and returns the pattern plus the onehot, pair and conflict indications.

Test Plan:
- Legal round (green 5 cycles, yellow 3 cycles, no all-red), run twice -> all err_*=0; cycles=1 after the first NS_Y->EW_G entry, 2 after the second; phase walks 1,2,4,5,1.
- Apply east=3'b011 for 1 cycle after reset -> err_onehot=1 two edges later, phase=SYNC, err_seq stays 0.
- EW green while NS green (all buses 001) -> err_conflict=1; err_pair=0.
- From EW_G jump straight to NS_G with no yellow -> err_seq=1, phase=SYNC; a later legal NS_G restarts tracking without setting err_time.
- Timing: yellow held 1 cycle -> err_time=1 at exit. Separately, yellow held 10 cycles -> err_time=1 when dwell reaches 9, before the phase exits.
- Set all errors, pulse rst_n=0 for 1 clk mid-phase -> next edge all flags=0, cycles=0, phase=SYNC.
